outstream: RTL and testbench

Output-side stream checker for the TIS array: the mirror of the input streamers. One instance sits on each bottom-row output port, consumes the values a node writes via the write/ready handshake, and compares each against a preloaded expected list. It reports progress, completion and the first mismatch to the puzzle controller.

---
 rtl/outstream.sv | 103 ++++++++++
 tb/tb_outstream.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outstream.sv
// Output-side stream checker: accepts words from a node and compares them to a preloaded list.
// Optional capture storage is enabled with `define OUTSTREAM_CAPTURE_EN.
module outstream (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         length,
  input  logic signed [10:0] expected [0:63],
  input  logic               write,
  input  logic signed [10:0] in,
  output logic               rready,
  output logic [5:0]         count,
  output logic               done,
  output logic               pass,
  output logic               mismatch,
  output logic [5:0]         err_idx,
  output logic signed [10:0] captured [0:63]
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state;
  logic [5:0] len_q;
  logic       xfer;
  logic       arm;
  logic       neq;
  logic       last;

  // Ready depends only on registered state so the node sees no loop through write.
  assign rready = (state == S_RUN) && (count < len_q);
  assign xfer   = write & rready;
  assign arm    = start & (state != S_RUN);
  assign neq    = (in != expected[count]);
  assign last   = ((count + 6'd1) == len_q);

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      count    <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (arm) begin
      len_q    <= length;
      count    <= '0;
      mismatch <= 1'b0;
      err_idx  <= '0;
      if (length == 6'd0) begin
        state <= S_DONE;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else begin
        state <= S_RUN;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else if (xfer) begin
      count <= count + 6'd1;
      if (neq && !mismatch) begin
        mismatch <= 1'b1;
        err_idx  <= count;
      end
      if (last) begin
        state <= S_DONE;
        done  <= 1'b1;
        pass  <= ~(mismatch | neq);
      end
    end
  end

`ifdef OUTSTREAM_CAPTURE_EN
  logic signed [10:0] cap_q [0:63];

  // Record each accepted word at its stream position; cleared on re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) cap_q[i] <= '0;
    end else if (arm) begin
      for (int i = 0; i < 64; i++) cap_q[i] <= '0;
    end else if (xfer) begin
      cap_q[count] <= in;
    end
  end

  // Expose the capture storage.
  always_comb begin
    for (int i = 0; i < 64; i++) captured[i] = cap_q[i];
  end
`else
  // No capture storage in this build.
  always_comb begin
    for (int i = 0; i < 64; i++) captured[i] = '0;
  end
`endif

endmodule

// File: tb/tb_outstream.sv
// Randomized self-checking bench for outstream against a queue-based model.
// Capture expectations follow OUTSTREAM_CAPTURE_EN.
module tb_outstream;

  logic               clk;
  logic               rst;
  logic               start;
  logic [5:0]         length;
  logic signed [10:0] exp_arr [0:63];
  logic               write;
  logic signed [10:0] in;
  logic               rready;
  logic [5:0]         count;
  logic               done;
  logic               pass;
  logic               mismatch;
  logic [5:0]         err_idx;
  logic signed [10:0] captured [0:63];

  int errors = 0;
  int checks = 0;

  // model state
  logic signed [10:0] m_recv [$];
  int                 m_len;
  logic               m_active;
  logic               m_done;

  outstream dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .expected(exp_arr), .write(write), .in(in), .rready(rready),
    .count(count), .done(done), .pass(pass), .mismatch(mismatch),
    .err_idx(err_idx), .captured(captured)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [5:0] m_count();
    return 6'(m_recv.size());
  endfunction

  function automatic logic m_mis();
    foreach (m_recv[i]) if (m_recv[i] !== exp_arr[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] m_err();
    foreach (m_recv[i]) if (m_recv[i] !== exp_arr[i]) return 6'(i);
    return 6'd0;
  endfunction

  function automatic logic m_rdy();
    return m_active && (m_recv.size() < m_len);
  endfunction

  function automatic logic m_pass();
    return m_done && !m_mis();
  endfunction

  function automatic logic signed [10:0] m_cap(input int i);
`ifdef OUTSTREAM_CAPTURE_EN
    if (i < m_recv.size()) return m_recv[i];
`endif
    return 11'sd0;
  endfunction

  function automatic int cap_bad();
    for (int i = 0; i < 64; i++) if (captured[i] !== m_cap(i)) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    m_recv.delete();
    m_len = 0;
    m_active = 0;
    m_done = 0;
  endfunction

  // one clock with write/in driven; model follows the handshake rule
  task automatic step(input logic w, input logic signed [10:0] v);
    logic xf;
    write = w;
    in = v;
    xf = m_rdy() && w;
    @(posedge clk); #1;
    if (xf) begin
      m_recv.push_back(v);
      if (m_recv.size() == m_len) begin
        m_active = 0;
        m_done = 1;
      end
    end
    write = 0;
  endtask

  task automatic arm(input int len);
    start = 1;
    length = 6'(len);
    @(posedge clk); #1;
    start = 0;
    if (!m_active) begin
      m_recv.delete();
      m_len = len;
      m_done = (len == 0);
      m_active = (len != 0);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; length = 0; write = 1; in = 11'sd5;
    #3;
    m_clear();
    checks++;
    if ({rready, count, done, pass, mismatch, err_idx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {rready, count, done, pass, mismatch, err_idx});
    end
    checks++;
    if (cap_bad() != -1) begin
      errors++;
      $display("FAIL reset_captured idx %0d got %0d want 0",
               cap_bad(), captured[cap_bad()]);
    end
    @(posedge clk); #1;
    rst = 0;
    step(1, 11'sd5);
    checks++;
    if (count !== 6'd0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL idle_write count %0d rready %b want 0 0", count, rready);
    end
  endtask

  task automatic test_clean();
    logic signed [10:0] v [3];
    v = '{11'sd5, -11'sd7, 11'sd999};
    for (int i = 0; i < 64; i++) exp_arr[i] = 11'($urandom);
    for (int i = 0; i < 3; i++) exp_arr[i] = v[i];
    arm(3);
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL clean_rready_after_start got %b want 1", rready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, v[i]);
      checks++;
      if (count !== 6'(i + 1)) begin
        errors++;
        $display("FAIL clean_count got %0d want %0d", count, i + 1);
      end
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || rready !== 1'b0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL clean_end done %b pass %b rready %b mis %b want 1 1 0 0",
               done, pass, rready, mismatch);
    end
    step(1, 11'sd123);
    checks++;
    if (count !== 6'd3 || rready !== 1'b0) begin
      errors++;
      $display("FAIL clean_stall count %0d rready %b want 3 0", count, rready);
    end
    checks++;
    if (cap_bad() != -1) begin
      errors++;
      $display("FAIL clean_captured idx %0d got %0d want %0d",
               cap_bad(), captured[cap_bad()], m_cap(cap_bad()));
    end
  endtask

  task automatic test_mismatch();
    logic signed [10:0] v [4];
    v = '{11'sd1, 11'sd9, 11'sd3, 11'sd0};
    for (int i = 0; i < 4; i++) exp_arr[i] = 11'(i + 1);
    arm(4);
    for (int i = 0; i < 4; i++) begin
      step(1, v[i]);
      if (i == 1) begin
        checks++;
        if (mismatch !== 1'b1 || err_idx !== 6'd1) begin
          errors++;
          $display("FAIL mis_second mis %b idx %0d want 1 1", mismatch, err_idx);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_idx !== 6'd1 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL mis_end done %b pass %b idx %0d mis %b want 1 0 1 1",
               done, pass, err_idx, mismatch);
    end
  endtask

  task automatic test_rearm();
    exp_arr[0] = -11'sd999;
    arm(1);
    checks++;
    if (mismatch !== 1'b0 || err_idx !== 6'd0 || done !== 1'b0 ||
        count !== 6'd0 || rready !== 1'b1) begin
      errors++;
      $display("FAIL rearm_clear mis %b idx %0d done %b cnt %0d rdy %b want 0 0 0 0 1",
               mismatch, err_idx, done, count, rready);
    end
    step(1, -11'sd999);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL rearm_pass done %b pass %b want 1 1", done, pass);
    end
    for (int i = 0; i < 3; i++) exp_arr[i] = 11'(10 * i);
    arm(3);
    step(1, 11'sd0);
    arm(5);
    checks++;
    if (count !== 6'd1 || rready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run cnt %0d rdy %b done %b want 1 1 0", count, rready, done);
    end
    step(1, 11'sd10);
    step(1, 11'sd20);
    checks++;
    if (count !== 6'd3 || done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run_end cnt %0d done %b pass %b want 3 1 1",
               count, done, pass);
    end
  endtask

  task automatic test_stall_zero();
    logic w [4];
    logic [5:0] want [4];
    w = '{1'b1, 1'b0, 1'b0, 1'b1};
    want = '{6'd1, 6'd1, 6'd1, 6'd2};
    exp_arr[0] = 11'sd7;
    exp_arr[1] = -11'sd1;
    arm(2);
    for (int i = 0, k = 0; i < 4; i++) begin
      step(w[i], exp_arr[k]);
      if (w[i]) k++;
      checks++;
      if (count !== want[i]) begin
        errors++;
        $display("FAIL stall_count step %0d got %0d want %0d", i, count, want[i]);
      end
    end
    arm(0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || rready !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL zero_len done %b pass %b rdy %b cnt %0d want 1 1 0 0",
               done, pass, rready, count);
    end
    step(1, 11'sd3);
    checks++;
    if (rready !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL zero_len_write rdy %b cnt %0d want 0 0", rready, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) exp_arr[i] = 11'(i);
    arm(5);
    step(1, 11'sd0);
    step(1, 11'sd9);
    write = 1;
    in = 11'sd2;
    #2 rst = 1;
    #1;
    m_clear();
    checks++;
    if ({rready, count, done, pass, mismatch, err_idx} !== 15'd0 || cap_bad() != -1) begin
      errors++;
      $display("FAIL reset_mid got %b want 0",
               {rready, count, done, pass, mismatch, err_idx});
    end
    @(posedge clk); #1;
    rst = 0;
    write = 0;
    step(1, 11'sd2);
    checks++;
    if (count !== 6'd0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after cnt %0d rdy %b want 0 0", count, rready);
    end
  endtask

  task automatic test_random();
    int len;
    int budget;
    logic signed [10:0] v;
    for (int r = 0; r < 25; r++) begin
      len = (r % 5 == 0) ? 63 : int'($urandom_range(1, 40));
      for (int i = 0; i < 64; i++) exp_arr[i] = 11'($urandom);
      arm(len);
      budget = len * 6 + 40;
      while (!m_done && budget > 0) begin
        budget--;
        if ($urandom_range(0, 19) == 0) begin
          arm(int'($urandom_range(0, 63)));
        end else begin
          v = ($urandom_range(0, 9) == 0) ? 11'($urandom) : exp_arr[m_recv.size()];
          step(($urandom_range(0, 3) != 0), v);
        end
        checks++;
        if (count !== m_count() || mismatch !== m_mis() || err_idx !== m_err() ||
            done !== m_done || pass !== m_pass() || rready !== m_rdy()) begin
          errors++;
          $display("FAIL rand run %0d cnt %0d/%0d mis %b/%b idx %0d/%0d done %b/%b pass %b/%b rdy %b/%b",
                   r, count, m_count(), mismatch, m_mis(), err_idx, m_err(),
                   done, m_done, pass, m_pass(), rready, m_rdy());
        end
      end
      checks++;
      if (budget == 0) begin
        errors++;
        $display("FAIL rand_timeout run %0d done %b want 1", r, done);
      end
      checks++;
      if (cap_bad() != -1) begin
        errors++;
        $display("FAIL rand_captured run %0d idx %0d got %0d want %0d",
                 r, cap_bad(), captured[cap_bad()], m_cap(cap_bad()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_mismatch();
    test_rearm();
    test_stall_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
